// File: rtl/mem_rmw_ctrl.sv
`timescale 1ns/1ps
// Single-outstanding load/store controller for a 32-bit word memory port.
// Sub-word stores are done as read-modify-write; misaligned or illegal requests return an error.
module mem_rmw_ctrl (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] req_addr_i,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_signed_i,
  input  logic [31:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic [31:0] mem_rd_addr_o,
  input  logic [31:0] mem_rd_data_i,
  output logic [31:0] mem_wr_addr_o,
  output logic [31:0] mem_wr_data_o,
  output logic        mem_wr_enable_o
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    DATA,
    RESP
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  state_t      state_q, state_d;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic        signed_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        err_pend_q;

  logic        accept;
  logic        req_err;
  logic [31:0] aligned_addr;
  logic [4:0]  lane_shift;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] lane_data;
  logic [31:0] merged_wdata;
  logic        wr_en_raw;

  // An erroring request parks in IDLE for one cycle with ready low, so its
  // response appears one edge after acceptance like a word store.
  assign req_ready_o  = (state_q == IDLE) && !err_pend_q;
  assign accept       = req_valid_i && req_ready_o;
  assign req_err      = (req_size_i == SZ_ILL)
                     || ((req_size_i == SZ_HALF) && req_addr_i[0])
                     || ((req_size_i == SZ_WORD) && (req_addr_i[1:0] != 2'b00));

  assign aligned_addr = {addr_q[31:2], 2'b00};
  assign lane_shift   = {addr_q[1:0], 3'b000};

  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign mem_rd_addr_o = aligned_addr;
  assign mem_wr_addr_o = aligned_addr;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (err_pend_q) begin
          state_d = RESP;
        end else if (accept && !req_err) begin
          if (req_we_i && (req_size_i == SZ_WORD)) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      WRITE:   state_d = RESP;
      READ:    state_d = DATA;
      DATA:    state_d = RESP;
      RESP: begin
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Lane extraction and extension for loads
  always_comb begin
    rd_byte  = mem_rd_data_i[lane_shift +: 8];
    rd_half  = addr_q[1] ? mem_rd_data_i[31:16] : mem_rd_data_i[15:0];
    load_val = mem_rd_data_i;
    case (size_q)
      SZ_BYTE: load_val = {{24{signed_q & rd_byte[7]}}, rd_byte};
      SZ_HALF: load_val = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_val = mem_rd_data_i;
    endcase
  end

  // Lane replacement for sub-word stores
  always_comb begin
    lane_mask = '0;
    lane_data = '0;
    case (size_q)
      SZ_BYTE: begin
        lane_mask = 32'h0000_00FF << lane_shift;
        lane_data = {4{wdata_q[7:0]}};
      end
      SZ_HALF: begin
        lane_mask = addr_q[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        lane_data = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_mask = '1;
        lane_data = wdata_q;
      end
    endcase
    merged_wdata = (mem_rd_data_i & ~lane_mask) | (lane_data & lane_mask);
  end

  always_comb begin
    wr_en_raw       = (state_q == WRITE) || ((state_q == DATA) && we_q);
    mem_wr_enable_o = wr_en_raw && rst_n_i;
    mem_wr_data_o   = '0;
    if (mem_wr_enable_o) begin
      mem_wr_data_o = (state_q == WRITE) ? wdata_q : merged_wdata;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= '0;
      signed_q   <= 1'b0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q     <= req_addr_i;
        we_q       <= req_we_i;
        size_q     <= req_size_i;
        signed_q   <= req_signed_i;
        wdata_q    <= req_wdata_i;
        rdata_q    <= '0;
        err_q      <= 1'b0;
        err_pend_q <= req_err;
      end
      if ((state_q == IDLE) && err_pend_q) begin
        err_q      <= 1'b1;
        err_pend_q <= 1'b0;
      end
      if ((state_q == DATA) && !we_q) begin
        rdata_q <= load_val;
      end
    end
  end

endmodule
